// File: rtl/timer_divider_bank.sv
// Bank of memory-mapped timer/divider channels.
// Per channel: CTRL, DIV, CNT, STATUS, a tick pulse and a divided clock.
module timer_divider_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_WIDTH = 32,
  parameter int DBITS = 32,
  parameter logic [DBITS-1:0] BASE_ADDR = 32'hF0000020,
  parameter int unsigned DEFAULT_DIV = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DBITS-1:0]  addr,
  input  logic [DBITS-1:0]  wrData,
  input  logic              wrEn,
  input  logic              rdEn,
  output logic [DBITS-1:0]  rdData,
  output logic [NUM_CH-1:0] tickOut,
  output logic [NUM_CH-1:0] clkOut,
  output logic              irq
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam cnt_t DIV_RST = cnt_t'(DEFAULT_DIV);
  localparam logic [DBITS-1:0] SPAN = DBITS'(NUM_CH * 16);

  logic [NUM_CH-1:0][2:0] ctrl_q, ctrl_d;
  cnt_t [NUM_CH-1:0]      div_q, div_d;
  cnt_t [NUM_CH-1:0]      cnt_q, cnt_d;
  logic [NUM_CH-1:0]      exp_q, exp_d;
  logic [NUM_CH-1:0]      tick_q, tick_d;
  logic [NUM_CH-1:0]      clko_q, clko_d;
  logic [DBITS-1:0]       rd_q, rd_d;

  logic [DBITS-1:0] off;
  logic             hit;
  logic [2:0]       ch;
  logic [1:0]       rsel;

  logic [NUM_CH-1:0] sel, wr_ctl, wr_div;
  logic [NUM_CH-1:0] wr_st, expire, ien;

  // Addresses below BASE_ADDR wrap to large offsets and miss.
  assign off  = addr - BASE_ADDR;
  assign hit  = off < SPAN;
  assign ch   = off[6:4];
  assign rsel = off[3:2];

  always_comb begin
    sel    = '0;
    wr_ctl = '0;
    wr_div = '0;
    wr_st  = '0;
    expire = '0;
    ien    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel[i]    = hit && (ch == 3'(i));
      wr_ctl[i] = wrEn && sel[i] && (rsel == 2'd0);
      wr_div[i] = wrEn && sel[i] && (rsel == 2'd1);
      wr_st[i]  = wrEn && sel[i] && (rsel == 2'd3);
      expire[i] = ctrl_q[i][0] && !wr_div[i]
                  && (cnt_q[i] == div_q[i]);
      ien[i]    = ctrl_q[i][2];
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    exp_d  = exp_q;
    tick_d = '0;
    clko_d = clko_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ctrl_q[i][0]) begin
        cnt_d[i] = expire[i] ? '0 : cnt_q[i] + cnt_t'(1);
      end
      if (expire[i]) begin
        tick_d[i] = 1'b1;
        clko_d[i] = ~clko_q[i];
        if (ctrl_q[i][1]) ctrl_d[i][0] = 1'b0;
      end
      // A clear racing a fresh expiry loses.
      exp_d[i] = (exp_q[i] & ~(wr_st[i] & wrData[0]))
                 | expire[i];
      if (wr_ctl[i]) begin
        ctrl_d[i] = wrData[2:0];
        if (wrData[0] && !ctrl_q[i][0]) cnt_d[i] = '0;
      end
      if (wr_div[i]) begin
        div_d[i] = wrData[CNT_WIDTH-1:0];
        cnt_d[i] = '0;
      end
    end
  end

  always_comb begin
    rd_d = '0;
    if (rdEn && hit) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch == 3'(i)) begin
          unique case (rsel)
            2'd0:    rd_d = DBITS'(ctrl_q[i]);
            2'd1:    rd_d = DBITS'(div_q[i]);
            2'd2:    rd_d = DBITS'(cnt_q[i]);
            default: rd_d = DBITS'(exp_q[i]);
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q <= '0;
      div_q  <= {NUM_CH{DIV_RST}};
      cnt_q  <= '0;
      exp_q  <= '0;
      tick_q <= '0;
      clko_q <= '0;
      rd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      exp_q  <= exp_d;
      tick_q <= tick_d;
      clko_q <= clko_d;
      rd_q   <= rd_d;
    end
  end

  assign rdData  = rd_q;
  assign tickOut = tick_q;
  assign clkOut  = clko_q;
  assign irq     = |(exp_q & ien);

endmodule

// File: tb/tb_timer_divider_bank.sv
// Directed bench for timer_divider_bank.
// Register table first, then multi-cycle timing sequences.
module tb_timer_divider_bank;

  localparam logic [31:0] B = 32'hF0000020;
  localparam logic [31:0] DDEF = 32'd5000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wrData = '0;
  logic        wrEn = 1'b0;
  logic        rdEn = 1'b0;
  logic [31:0] rdData;
  logic [3:0]  tickOut;
  logic [3:0]  clkOut;
  logic        irq;

  int checks = 0;
  int failures = 0;

  timer_divider_bank dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wrData  (wrData),
    .wrEn    (wrEn),
    .rdEn    (rdEn),
    .rdData  (rdData),
    .tickOut (tickOut),
    .clkOut  (clkOut),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    string       nm;
  } vec_t;

  vec_t tbl [23];

  function automatic logic [31:0] ra(int c, int r);
    return B + 32'(16 * c) + 32'(4 * r);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    addr = a;
    wrData = d;
    wrEn = 1'b1;
    step();
    wrEn = 1'b0;
  endtask

  task automatic rdchk(input string nm,
                       input logic [31:0] a,
                       input logic [31:0] exp);
    addr = a;
    rdEn = 1'b1;
    step();
    rdEn = 1'b0;
    chk(nm, rdData, exp);
  endtask

  initial begin
    tbl[0]  = '{1'b0, ra(0, 0), 32'd0, "ctrl0_rst"};
    tbl[1]  = '{1'b0, ra(0, 1), DDEF, "div0_rst"};
    tbl[2]  = '{1'b0, ra(3, 1), DDEF, "div3_rst"};
    tbl[3]  = '{1'b0, ra(0, 2), 32'd0, "cnt0_rst"};
    tbl[4]  = '{1'b0, ra(0, 3), 32'd0, "stat0_rst"};
    tbl[5]  = '{1'b1, ra(1, 1), 32'h12345678, "w"};
    tbl[6]  = '{1'b0, ra(1, 1), 32'h12345678, "div1_rw"};
    tbl[7]  = '{1'b1, ra(1, 0), 32'hFFFFFFF8, "w"};
    tbl[8]  = '{1'b0, ra(1, 0), 32'd0, "ctrl1_rsvd"};
    tbl[9]  = '{1'b1, ra(1, 0), 32'd6, "w"};
    tbl[10] = '{1'b0, ra(1, 0), 32'd6, "ctrl1_rw"};
    tbl[11] = '{1'b1, ra(1, 2), 32'h55, "w"};
    tbl[12] = '{1'b0, ra(1, 2), 32'd0, "cnt1_ro"};
    tbl[13] = '{1'b1, B + 32'h48, 32'hFFFFFFFF, "w"};
    tbl[14] = '{1'b0, B + 32'h48, 32'd0, "unmap_rd"};
    tbl[15] = '{1'b0, ra(3, 1), DDEF, "div3_unmap"};
    tbl[16] = '{1'b1, B - 32'h10, 32'd1, "w"};
    tbl[17] = '{1'b0, ra(0, 0), 32'd0, "ctrl0_below"};
    tbl[18] = '{1'b0, B + 32'h7, DDEF, "div0_lowbits"};
    tbl[19] = '{1'b1, ra(1, 0), 32'd0, "w"};
    tbl[20] = '{1'b0, ra(1, 0), 32'd0, "ctrl1_clr"};
    tbl[21] = '{1'b1, ra(0, 3), 32'd1, "w"};
    tbl[22] = '{1'b0, ra(0, 3), 32'd0, "stat0_w1c"};

    // Reset with a concurrent write that must lose.
    addr = ra(0, 0);
    wrData = 32'd1;
    wrEn = 1'b1;
    step();
    step();
    wrEn = 1'b0;
    chk("rst_rd", rdData, 0);
    chk("rst_tick", 32'(tickOut), 0);
    chk("rst_clk", 32'(clkOut), 0);
    chk("rst_irq", 32'(irq), 0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      if (tbl[i].wr) wr(tbl[i].a, tbl[i].d);
      else rdchk(tbl[i].nm, tbl[i].a, tbl[i].d);
    end

    // Periodic ch0, DIV=3.
    wr(ra(0, 1), 3);
    wr(ra(0, 0), 1);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("a_tick", 32'(tickOut[0]), 32'(k % 4 == 0));
      chk("a_clk", 32'(clkOut[0]), 32'((k / 4) % 2));
    end
    rdchk("a_stat", ra(0, 3), 1);
    wr(ra(0, 0), 0);
    chk("a_irq", 32'(irq), 0);
    wr(ra(0, 3), 1);
    rdchk("a_stat_clr", ra(0, 3), 0);

    // One-shot ch1, DIV=2.
    wr(ra(1, 1), 2);
    wr(ra(1, 0), 3);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("b_tick", 32'(tickOut[1]), 32'(k == 3));
    end
    rdchk("b_ctrl", ra(1, 0), 2);
    rdchk("b_stat", ra(1, 3), 1);

    // ch2 DIV=0 with IRQ.
    wr(ra(2, 1), 0);
    chk("c_irq0", 32'(irq), 0);
    wr(ra(2, 0), 5);
    chk("c_irq_en", 32'(irq), 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("c_tick", 32'(tickOut[2]), 1);
      chk("c_irq", 32'(irq), 1);
    end
    wr(ra(2, 3), 1);
    chk("c_irq_w1c", 32'(irq), 1);
    rdchk("c_stat", ra(2, 3), 1);
    wr(ra(2, 0), 0);
    wr(ra(2, 3), 1);
    rdchk("c_stat_clr", ra(2, 3), 0);
    chk("c_irq_off", 32'(irq), 0);

    // DIV rewrite mid-count restarts ch0.
    wr(ra(0, 1), 100);
    wr(ra(0, 0), 1);
    repeat (49) step();
    rdchk("d_cnt", ra(0, 2), 49);
    wr(ra(0, 1), 5);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("d_tick", 32'(tickOut[0]), 32'(k == 6));
    end
    rdchk("d_div", ra(0, 1), 5);

    // Same-cycle read and write of one register.
    addr = ra(3, 1);
    wrData = 32'd7;
    wrEn = 1'b1;
    rdEn = 1'b1;
    step();
    wrEn = 1'b0;
    rdEn = 1'b0;
    chk("e_rdw_old", rdData, DDEF);
    rdchk("e_rdw_new", ra(3, 1), 7);

    // Reset mid-count, mid-read, with a write pending.
    wr(ra(3, 0), 1);
    repeat (3) step();
    addr = ra(3, 1);
    wrData = 32'd9;
    wrEn = 1'b1;
    rdEn = 1'b1;
    reset = 1'b0;
    step();
    reset = 1'b1;
    wrEn = 1'b0;
    rdEn = 1'b0;
    chk("f_rd", rdData, 0);
    chk("f_tick", 32'(tickOut), 0);
    chk("f_clk", 32'(clkOut), 0);
    chk("f_irq", 32'(irq), 0);
    rdchk("f_div3", ra(3, 1), DDEF);
    rdchk("f_div0", ra(0, 1), DDEF);
    rdchk("f_cnt0", ra(0, 2), 0);
    rdchk("f_cnt3", ra(3, 2), 0);
    rdchk("f_ctrl0", ra(0, 0), 0);
    chk("f_tick2", 32'(tickOut), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
